// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply/divide unit behind a single start/done handshake.
// Multiply is radix-2 shift-add and divide is restoring division, both on operand
// magnitudes. A one-cycle FIX state applies the sign correction afterwards.
// hi = upper product or remainder; lo = lower product or quotient.
// Optional build macro MULDIV_EARLY_OUT_EN: a multiply leaves CALC as soon as
// the remaining multiplier bits are all zero. Results are identical either way.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_FIX  = 3'd2;
  localparam logic [2:0] S_DZ   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             neg_lo_q, neg_lo_d;   // product sign, or quotient sign
  logic             neg_hi_q, neg_hi_d;   // product sign, or remainder sign
  logic [W2-1:0]    acc_q, acc_d;         // product accumulator; remainder in upper half
  logic [W2-1:0]    opa_q, opa_d;         // shifting multiplicand, or divisor in lower half
  logic [WIDTH-1:0] opb_q, opb_d;         // shifting multiplier, or dividend/quotient
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  // Operand magnitudes and signs captured at start
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sign_a = is_signed & op_a[WIDTH-1];
  assign sign_b = is_signed & op_b[WIDTH-1];
  assign mag_a  = sign_a ? -op_a : op_a;
  assign mag_b  = sign_b ? -op_b : op_b;

  // One shift-add multiply step
  logic [W2-1:0] prod_sum;
  assign prod_sum = opb_q[0] ? (acc_q + opa_q) : acc_q;

  // One restoring divide step: shift in the next dividend bit, trial-subtract
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt;
  assign div_sh   = {acc_q[W2-1:WIDTH], opb_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opa_q[WIDTH-1:0]};
  assign div_diff = div_sh - {1'b0, opa_q[WIDTH-1:0]};
  assign rem_nxt  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];

  // Sign-corrected results written in FIX
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_lo_q ? -opb_q : opb_q;
  assign rem_fix  = neg_hi_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

  // Last CALC iteration
  logic calc_last;
`ifdef MULDIV_EARLY_OUT_EN
  assign calc_last = (cnt_q == CW'(WIDTH - 1)) || (!op_q && (opb_q[WIDTH-1:1] == '0));
`else
  assign calc_last = (cnt_q == CW'(WIDTH - 1));
`endif

  // Next-state, datapath and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = op ? sign_a : (sign_a ^ sign_b);
          cnt_d    = '0;
          acc_d    = '0;
          dz_d     = 1'b0;
          if (op) begin
            opa_d = {{WIDTH{1'b0}}, mag_b};
            opb_d = mag_a;
          end else begin
            opa_d = {{WIDTH{1'b0}}, mag_a};
            opb_d = mag_b;
          end
          state_d = (op && (op_b == '0)) ? S_DZ : S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (!op_q) begin
          acc_d = prod_sum;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = {rem_nxt, acc_q[WIDTH-1:0]};
          opb_d = {opb_q[WIDTH-2:0], div_ge};
        end
        if (calc_last) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q) begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = S_DONE;
      end
      S_DZ: begin
        dz_d    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_FIX) || (state_d == S_DZ);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule
